// File: rtl/stl_pkg.sv
// Shared helpers for the standard-library blocks.
package stl_pkg;

  // Address width that never collapses to zero, so a 2-entry FIFO still gets one index bit.
  function automatic int clog2_min1(input int n);
    int r;
    if (n <= 32'sd2) begin
      r = 32'sd1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/stl_reg.sv
// Single enable-qualified storage word, used as one FIFO entry.
module stl_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: load on enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (i_wen) begin
      q_d = i_d;
    end else begin
      q_d = q_q;
    end
  end

  // Word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/stl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Optional zero-latency empty bypass: define STL_FIFO_BYPASS_EN.
module stl_sync_fifo
  import stl_pkg::*;
#(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  localparam int                AW        = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_rvalid,
  input  logic             i_rready,
  output logic [WIDTH-1:0] o_dout,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             empty_s, full_s;
  logic             push_s, pop_s, rvalid_s;
  logic [WIDTH-1:0] head_s, dout_s;
  logic [WIDTH-1:0] mem_s [DEPTH];

  // Status decoded purely from the registered pointer pair.
  always_comb begin
    empty_s = (wptr_q == rptr_q);
    full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    head_s  = mem_s[rptr_q[AW-1:0]];
  end

`ifdef STL_FIFO_BYPASS_EN
  // Empty FIFO forwards the incoming word; it is only stored if the consumer stalls.
  always_comb begin
    rvalid_s = 1'b0;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    dout_s   = RESET_VAL;
    if (empty_s) begin
      rvalid_s = i_wen & ~i_flush;
      push_s   = i_wen & ~i_rready;
      pop_s    = 1'b0;
      if (rvalid_s) begin
        dout_s = i_din;
      end else begin
        dout_s = RESET_VAL;
      end
    end else begin
      rvalid_s = 1'b1;
      push_s   = i_wen & ~full_s;
      pop_s    = i_rready;
      dout_s   = head_s;
    end
  end
`else
  // Registered-only read side: one cycle from write to visibility.
  always_comb begin
    rvalid_s = ~empty_s;
    push_s   = i_wen & ~full_s;
    pop_s    = rvalid_s & i_rready;
    dout_s   = RESET_VAL;
    if (rvalid_s) begin
      dout_s = head_s;
    end else begin
      dout_s = RESET_VAL;
    end
  end
`endif

  // Pointer advance; flush wins over any push or pop in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (i_flush) begin
      wptr_d = PTR_ZERO;
      rptr_d = PTR_ZERO;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= PTR_ZERO;
      rptr_q <= PTR_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic wen_s;
    assign wen_s = push_s && (wptr_q[AW-1:0] == AW'(i));
    stl_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_wen (wen_s),
      .i_d   (i_din),
      .o_q   (mem_s[i])
    );
  end

  assign o_full   = full_s;
  assign o_rvalid = rvalid_s;
  assign o_dout   = dout_s;
  assign o_count  = wptr_q - rptr_q;

endmodule

// File: tb/tb_stl_sync_fifo.sv
// Scoreboard bench for stl_sync_fifo (WIDTH=8, DEPTH=4) against a queue reference model.
module tb_stl_sync_fifo;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'h00;
`ifdef STL_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_wen = 1'b0;
  logic [WIDTH-1:0] i_din = 8'h00;
  logic             i_rready = 1'b0;
  logic             o_full;
  logic             o_rvalid;
  logic [WIDTH-1:0] o_dout;
  logic [2:0]       o_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];

  stl_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_wen(i_wen), .i_din(i_din),
    .o_full(o_full), .o_rvalid(o_rvalid), .i_rready(i_rready), .o_dout(o_dout),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the queue model predicts outputs and the post-edge contents.
  task automatic cycle(input bit fl, input bit wen, input logic [7:0] din, input bit rr);
    int n;
    bit ev;
    logic [7:0] ed;
    i_flush = fl; i_wen = wen; i_din = din; i_rready = rr;
    n  = mq.size();
    ev = (n > 0) || (BYP && n == 0 && wen && !fl);
    ed = (n > 0) ? mq[0] : (ev ? din : RV);
    if (ev && rr) exp_q.push_back(ed);
    @(negedge clk);
    chk("count", int'(o_count), n);
    chk("full", int'(o_full), int'(n == DEPTH));
    chk("rvalid", int'(o_rvalid), int'(ev));
    if (!(ev && rr)) chk("dout", int'(o_dout), int'(ed));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else if (!(BYP && n == 0 && ev && rr)) begin
      if (ev && rr) void'(mq.pop_front());
      if (wen && n < DEPTH) mq.push_back(din);
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_flush = 1'b0; i_wen = 1'b0; i_din = 8'h00; i_rready = 1'b0;
  endtask

  // Monitor: every accepted head word must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_rvalid && i_rready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", int'(o_dout), -1);
        else chk("pop_data", int'(o_dout), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3;
    chk("rst_count", int'(o_count), 0);
    chk("rst_rvalid", int'(o_rvalid), 0);
    chk("rst_full", int'(o_full), 0);
    chk("rst_dout", int'(o_dout), int'(RV));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full with the consumer stalled
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0);
    cycle(1'b0, 1'b1, 8'h44, 1'b0);
    idle_inputs();
    chk("t1_count", int'(o_count), 4);
    chk("t1_full", int'(o_full), 1);
    chk("t1_head", int'(o_dout), 8'h11);

    // Push at full is dropped while the pop proceeds
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    idle_inputs();
    chk("t2_count", int'(o_count), 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_empty_dout", int'(o_dout), int'(RV));

    // Streaming at occupancy one through two pointer wraps
    cycle(1'b0, 1'b1, 8'hA0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b1);
    idle_inputs();
    chk("t3_count", int'(o_count), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    idle_inputs();
    chk("t4_count", int'(o_count), 0);
    chk("t4_rvalid", int'(o_rvalid), 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset between edges with two entries held
    cycle(1'b0, 1'b1, 8'hD1, 1'b0);
    cycle(1'b0, 1'b1, 8'hD2, 1'b0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rvalid", int'(o_rvalid), 0);
    chk("t5_count", int'(o_count), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef STL_FIFO_BYPASS_EN
    i_wen = 1'b1; i_din = 8'hA5; i_rready = 1'b1;
    #1;
    chk("t6_bypass_rvalid", int'(o_rvalid), 1);
    chk("t6_bypass_dout", int'(o_dout), 8'hA5);
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_inputs();
    chk("t6_consumed_count", int'(o_count), 0);
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    idle_inputs();
    chk("t6_stored_count", int'(o_count), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
`endif

    // Randomised traffic with rare flushes
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 32) == 0, ($urandom % 3) != 0, 8'($urandom), ($urandom % 2) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle_inputs();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_count", int'(o_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
